// File: rtl/ram_param_clr_pkg.sv
// Shared types and defaults for the parametrised clearable RAM.
package ram_param_clr_pkg;

    // Sweep FSM encoding: CLEAR is the reset state, READY serves user traffic.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_e;

    // Default geometry matches the original 16K x 16 data memory.
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 14;

endpackage : ram_param_clr_pkg

// File: rtl/ram_param_clr_if.sv
// CPU-side data-memory bus: address/data/write/clear requests in, busy/read data out.
interface ram_param_clr_if
    import ram_param_clr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] in;
    logic              load;
    logic              clr;
    logic              busy;
    logic [DATA_W-1:0] out;

    // CPU side drives requests and observes the memory.
    modport master (
        output address, in, load, clr,
        input  busy, out
    );

    // Memory side.
    modport slave (
        input  address, in, load, clr,
        output busy, out
    );
endinterface : ram_param_clr_if

// File: rtl/ram_param_clr_clear_fsm.sv
// Clear sweep controller: walks a pointer across every word after reset or
// on a clear request, and reports busy while the sweep is running.
module ram_param_clr_clear_fsm
    import ram_param_clr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              sweep_we_o,
    output logic [ADDR_W-1:0] sweep_addr_o
);

    // Pointer only ever compares against the last word, so it never wraps.
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    ram_state_e        state_q;
    logic [ADDR_W-1:0] ptr_q;

    // State and sweep pointer; clr is only honoured once the sweep is done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= {ADDR_W{1'b0}};
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == PTR_LAST) begin
                        state_q <= ST_READY;
                        ptr_q   <= {ADDR_W{1'b0}};
                    end else begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= ptr_q + ADDR_W'(1'b1);
                    end
                end
                ST_READY: begin
                    if (clr_i) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= {ADDR_W{1'b0}};
                    end else begin
                        state_q <= ST_READY;
                        ptr_q   <= ptr_q;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ptr_q   <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // All outputs come straight from the state/pointer registers.
    assign busy_o       = (state_q == ST_CLEAR);
    assign sweep_we_o   = (state_q == ST_CLEAR);
    assign sweep_addr_o = ptr_q;

endmodule : ram_param_clr_clear_fsm

// File: rtl/ram_param_clr.sv
// Parametrised single-port RAM with a built-in clear sweep and optional
// registered read port. Write port is owned by the sweep while busy.
module ram_param_clr
    import ram_param_clr_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}},
    parameter bit                REG_OUT   = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_param_clr_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              busy_s;
    logic              sweep_we_s;
    logic [ADDR_W-1:0] sweep_addr_s;

    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;

    ram_param_clr_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (bus.clr),
        .busy_o       (busy_s),
        .sweep_we_o   (sweep_we_s),
        .sweep_addr_o (sweep_addr_s)
    );

    // Write-port mux: sweep owns the port while clearing; a clear request
    // in READY takes priority over a same-cycle user write.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = {ADDR_W{1'b0}};
        wdata_s = {DATA_W{1'b0}};
        if (sweep_we_s) begin
            we_s    = 1'b1;
            waddr_s = sweep_addr_s;
            wdata_s = CLEAR_VAL;
        end else begin
            we_s    = bus.load & ~bus.clr;
            waddr_s = bus.address;
            wdata_s = bus.in;
        end
    end

    // Storage array; intentionally unreset, the sweep initialises it.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[waddr_s] <= wdata_s;
        end else begin
            mem_q[waddr_s] <= mem_q[waddr_s];
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic [DATA_W-1:0] out_q;

            // Registered read, read-first on a same-address write; forced to
            // the clear value while a sweep runs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q <= CLEAR_VAL;
                end else if (busy_s) begin
                    out_q <= CLEAR_VAL;
                end else begin
                    out_q <= mem_q[bus.address];
                end
            end

            assign bus.out = out_q;
        end else begin : g_comb_out
            // Combinational read; shows the clear value while a sweep runs.
            always_comb begin
                if (busy_s) begin
                    bus.out = CLEAR_VAL;
                end else begin
                    bus.out = mem_q[bus.address];
                end
            end
        end
    endgenerate

    assign bus.busy = busy_s;

endmodule : ram_param_clr
